// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop handshake, status and RAM-side signals of the RAM-backed FIFO controller.
// slave is the controller's view; master is the view of the surrounding logic.
interface ram_fifo_ctrl_if #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned ADDR_W = 3
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              almost_full;
   logic [ADDR_W+1:0] level;
   logic              ram_write_en;
   logic [ADDR_W-1:0] ram_write_addr;
   logic [DATA_W-1:0] ram_write_data;
   logic              ram_read_en;
   logic [ADDR_W-1:0] ram_read_addr;
   logic [DATA_W-1:0] ram_read_data;

   modport slave (
      input  flush, in_valid, in_data, out_ready, ram_read_data,
      output in_ready, out_valid, out_data, almost_full, level,
             ram_write_en, ram_write_addr, ram_write_data,
             ram_read_en, ram_read_addr
   );

   modport master (
      output flush, in_valid, in_data, out_ready, ram_read_data,
      input  in_ready, out_valid, out_data, almost_full, level,
             ram_write_en, ram_write_addr, ram_write_data,
             ram_read_en, ram_read_addr
   );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Show-ahead FIFO controller driving an external dual-port RAM; the RAM's
// registered read port acts as the single output stage.
module ram_fifo_ctrl #(
   parameter int unsigned DATA_W   = 4,
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned AFULL_TH = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   ram_fifo_ctrl_if.slave bus
);
   localparam logic [ADDR_W:0]   FULL_C  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   AFULL_C = AFULL_TH[ADDR_W:0];
   localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_ONE = CNT_ONE[ADDR_W-1:0];

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              out_valid_q, out_valid_d;
   logic              in_ready;
   logic              push;
   logic              fetch;
   logic [DATA_W-1:0] wdata;

   always_comb begin
      in_ready    = (count_q != FULL_C);
      push        = bus.in_valid & in_ready & ~bus.flush;
      // Refill the read register whenever it is empty or being drained this cycle.
      fetch       = (count_q != '0) & (~out_valid_q | bus.out_ready) & ~bus.flush;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      if (bus.flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         out_valid_d = 1'b0;
      end else begin
         if (push)  wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (fetch) rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({push, fetch})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
         if (fetch)                           out_valid_d = 1'b1;
         else if (out_valid_q & bus.out_ready) out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign wdata              = bus.in_data;
   assign bus.in_ready       = in_ready;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_data       = bus.ram_read_data;
   assign bus.almost_full    = (count_q >= AFULL_C);
   assign bus.level          = {1'b0, count_q} + {{(ADDR_W+1){1'b0}}, out_valid_q};
   assign bus.ram_write_en   = push;
   assign bus.ram_write_addr = wr_ptr_q;
   assign bus.ram_write_data = wdata;
   assign bus.ram_read_en    = fetch;
   assign bus.ram_read_addr  = rd_ptr_q;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: directed scenarios plus random traffic, checked
// against a queue-based FIFO model and a behavioural RAM.
module tb_ram_fifo_ctrl;
   localparam int DEPTH = 8;
   localparam int AFULL = 6;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   ram_fifo_ctrl_if #(.DATA_W(4), .ADDR_W(3)) bus ();

   ram_fifo_ctrl #(.DATA_W(4), .ADDR_W(3), .AFULL_TH(AFULL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Behavioural dual-port RAM with registered, holding read port.
   logic [3:0] ram_mem [DEPTH];
   logic [3:0] ram_rd_q;
   always @(posedge clk) begin
      if (bus.ram_write_en) ram_mem[bus.ram_write_addr] <= bus.ram_write_data;
      if (bus.ram_read_en)  ram_rd_q <= ram_mem[bus.ram_read_addr];
   end
   assign bus.ram_read_data = ram_rd_q;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: words still in RAM, plus the output stage.
   int mq[$];
   bit m_ov;
   int m_od;
   int n_wr;
   int n_rd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_ov = 0;
      m_od = 0;
      n_wr = 0;
      n_rd = 0;
   endtask

   task automatic step(input logic v, input logic [3:0] d, input logic r, input logic f);
      int sz;
      bit rdy_e, push_e, fetch_e;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = r;
      bus.flush     = f;
      #4;
      sz      = mq.size();
      rdy_e   = (sz != DEPTH);
      push_e  = v && rdy_e && !f;
      fetch_e = (sz != 0) && (!m_ov || r) && !f;
      chk("in_ready", {31'b0, bus.in_ready}, {31'b0, rdy_e});
      chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_ov});
      if (m_ov) chk("out_data", {28'b0, bus.out_data}, m_od);
      chk("level", {27'b0, bus.level}, sz + int'(m_ov));
      chk("almost_full", {31'b0, bus.almost_full}, {31'b0, (sz >= AFULL)});
      chk("ram_write_en", {31'b0, bus.ram_write_en}, {31'b0, push_e});
      chk("ram_read_en", {31'b0, bus.ram_read_en}, {31'b0, fetch_e});
      if (push_e) begin
         chk("ram_write_addr", {29'b0, bus.ram_write_addr}, n_wr % DEPTH);
         chk("ram_write_data", {28'b0, bus.ram_write_data}, {28'b0, d});
      end
      if (fetch_e) chk("ram_read_addr", {29'b0, bus.ram_read_addr}, n_rd % DEPTH);
      @(posedge clk);
      if (f) begin
         model_clear();
      end else begin
         if (fetch_e) begin
            m_od = mq.pop_front();
            m_ov = 1;
            n_rd++;
         end else if (m_ov && r) begin
            m_ov = 0;
         end
         if (push_e) begin
            mq.push_back(int'(d));
            n_wr++;
         end
      end
      #1;
   endtask

   initial begin
      logic [3:0] val;
      // Reset state
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      bus.flush     = 1'b0;
      rst_n         = 1'b0;
      model_clear();
      #1;
      chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_level", {27'b0, bus.level}, 32'd0);
      chk("rst_almost_full", {31'b0, bus.almost_full}, 32'd0);
      chk("rst_write_en", {31'b0, bus.ram_write_en}, 32'd0);
      chk("rst_read_en", {31'b0, bus.ram_read_en}, 32'd0);
      #21 rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: fill with out_ready low until push is refused
      val = 4'h1;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, val, 1'b0, 1'b0);
         val = val + 4'h1;
      end
      chk("fill_level", {27'b0, bus.level}, 32'd9);
      chk("fill_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("fill_almost_full", {31'b0, bus.almost_full}, 32'd1);
      chk("fill_head", {28'b0, bus.out_data}, 32'h1);

      // stall: head must hold with no fetch
      for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b0, 1'b0);

      // 2: drain
      for (int i = 0; i < 10; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
      chk("drain_level", {27'b0, bus.level}, 32'd0);
      chk("drain_out_valid", {31'b0, bus.out_valid}, 32'd0);

      // 3: single push into empty FIFO, latency two edges
      step(1'b1, 4'hA, 1'b0, 1'b0);
      chk("lat_read_en", {31'b0, bus.ram_read_en}, 32'd1);
      step(1'b0, 4'h0, 1'b0, 1'b0);
      chk("lat_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("lat_out_data", {28'b0, bus.out_data}, 32'hA);
      step(1'b0, 4'h0, 1'b1, 1'b0);

      // 4: streaming across pointer wrap
      val = 4'h0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, val, 1'b1, 1'b0);
         val = val + 4'h1;
      end
      chk("stream_level", {27'b0, bus.level}, 32'd2);
      for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b1, 1'b0);

      // 5: flush at level 5 with a push pending
      for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 3), 1'b0, 1'b0);
      chk("pre_flush_level", {27'b0, bus.level}, 32'd5);
      step(1'b1, 4'hF, 1'b0, 1'b1);
      chk("flush_level", {27'b0, bus.level}, 32'd0);
      chk("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
      step(1'b1, 4'h6, 1'b0, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b0);
      chk("post_flush_data", {28'b0, bus.out_data}, 32'h6);
      step(1'b0, 4'h0, 1'b1, 1'b0);

      // 6: asynchronous reset mid-stream
      for (int i = 0; i < 6; i++) step(1'b1, 4'(i), 1'b1, 1'b0);
      chk("pre_rst_out_valid", {31'b0, bus.out_valid}, 32'd1);
      #3;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      chk("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("arst_level", {27'b0, bus.level}, 32'd0);
      chk("arst_write_en", {31'b0, bus.ram_write_en}, 32'd0);
      chk("arst_read_en", {31'b0, bus.ram_read_en}, 32'd0);
      chk("arst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      model_clear();
      #7 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 9), 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 4'h0, 1'b1, 1'b0);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 31) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
